// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU package: register-address width, forwarding select codes,
// hazard FSM state encodings and the packed stage-control bundle.
package pipeline_hazard_ctrl_pkg;

  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_ALU     = 2'b01,
    FWD_RAM     = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic exwb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE   = '0;
  localparam ctrl_t CTRL_RUN      = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, exwb_en: 1'b1,
                                      if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam ctrl_t CTRL_BRANCH   = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, exwb_en: 1'b1,
                                      if_id_flush: 1'b1, id_ex_flush: 1'b1};
  // ID/EX stays enabled during a load-use stall so the bubble is actually clocked in.
  localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, exwb_en: 1'b1,
                                      if_id_flush: 1'b0, id_ex_flush: 1'b1};

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detection and ALU operand forwarding selects.
module hazard_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = pipeline_hazard_ctrl_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_re,
  input  logic [ADDR_W-1:0] ex_dest_addr,
  input  logic [ADDR_W-1:0] ex_rs_addr,
  input  logic [ADDR_W-1:0] ex_rt_addr,
  input  logic              wb_reg_wb,
  input  logic              wb_mem_re,
  input  logic [ADDR_W-1:0] wb_dest_addr,
  output logic              load_use,
  output fwd_sel_e          fwd_a_sel,
  output fwd_sel_e          fwd_b_sel
);

  // Register 0 is not special-cased: a load to r0 still stalls a dependent reader.
  assign load_use = ex_mem_re &
                    ((id_uses_rs & (id_rs_addr == ex_dest_addr)) |
                     (id_uses_rt & (id_rt_addr == ex_dest_addr)));

  always_comb begin
    fwd_a_sel = FWD_REGFILE;
    fwd_b_sel = FWD_REGFILE;
    if (wb_reg_wb && (wb_dest_addr == ex_rs_addr)) fwd_a_sel = wb_mem_re ? FWD_RAM : FWD_ALU;
    if (wb_reg_wb && (wb_dest_addr == ex_rt_addr)) fwd_b_sel = wb_mem_re ? FWD_RAM : FWD_ALU;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 10-bit pipelined CPU: load-use
// stalls, multi-cycle RAM waits with timeout, and taken-branch flushes.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W  = pipeline_hazard_ctrl_pkg::ADDR_W,
  parameter int MEM_TMO = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_re,
  input  logic [ADDR_W-1:0] ex_dest_addr,
  input  logic [ADDR_W-1:0] ex_rs_addr,
  input  logic [ADDR_W-1:0] ex_rt_addr,
  input  logic              wb_reg_wb,
  input  logic              wb_mem_re,
  input  logic [ADDR_W-1:0] wb_dest_addr,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              exwb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TMO + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_set;
  logic              run_eval;
  ctrl_t             ctrl;
  logic              load_use;
  fwd_sel_e          fwd_a_raw, fwd_b_raw;

  hazard_fwd_unit #(.ADDR_W(ADDR_W)) u_fwd (
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_re    (ex_mem_re),
    .ex_dest_addr (ex_dest_addr),
    .ex_rs_addr   (ex_rs_addr),
    .ex_rt_addr   (ex_rt_addr),
    .wb_reg_wb    (wb_reg_wb),
    .wb_mem_re    (wb_mem_re),
    .wb_dest_addr (wb_dest_addr),
    .load_use     (load_use),
    .fwd_a_sel    (fwd_a_raw),
    .fwd_b_sel    (fwd_b_raw)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    ctrl        = CTRL_FREEZE;
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_set = 1'b0;
    run_eval    = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        if (mem_ack) begin
          wait_d   = '0;
          run_eval = 1'b1;
        end else if (wait_q == WAIT_W'(MEM_TMO - 1)) begin
          timeout_set = 1'b1;
          wait_d      = '0;
          state_d     = RUN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: run_eval = 1'b1;
    endcase

    // LU_STALL lasts one cycle and is evaluated exactly like RUN; the ack cycle of a wait is too.
    if (run_eval) begin
      if (mem_req && !mem_ack) begin
        ctrl    = CTRL_FREEZE;
        wait_d  = '0;
        state_d = MEM_WAIT;
      end else if (branch_taken) begin
        ctrl    = CTRL_BRANCH;
        state_d = RUN;
      end else if (load_use) begin
        ctrl    = CTRL_LOAD_USE;
        state_d = LU_STALL;
      end else begin
        ctrl    = CTRL_RUN;
        state_d = RUN;
      end
    end

    if (!reset) ctrl = CTRL_FREEZE;
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign exwb_en     = ctrl.exwb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign fwd_a_sel   = reset ? fwd_a_raw : FWD_REGFILE;
  assign fwd_b_sel   = reset ? fwd_b_raw : FWD_REGFILE;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values; reset is synchronous, so it is tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout_set) mem_timeout <= 1'b1;
      if (!ctrl.pc_en && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the combinational
// hazard/forwarding decisions plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] id_rs_addr, id_rt_addr, ex_dest_addr, ex_rs_addr, ex_rt_addr, wb_dest_addr;
  logic       id_uses_rs, id_uses_rt, ex_mem_re, wb_reg_wb, wb_mem_re;
  logic       branch_taken, mem_req, mem_ack;

  logic        pc_en, if_id_en, id_ex_en, exwb_en, if_id_flush, id_ex_flush, mem_timeout;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_exwb_en, s_if_id_flush, s_id_ex_flush, s_mem_timeout;
  logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_passed = 0;

  localparam logic [5:0] C_RUN = 6'b111100;
  localparam logic [5:0] C_LU  = 6'b001101;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_FRZ = 6'b000000;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_re(ex_mem_re), .ex_dest_addr(ex_dest_addr),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .wb_reg_wb(wb_reg_wb), .wb_mem_re(wb_mem_re), .wb_dest_addr(wb_dest_addr),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .exwb_en(exwb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  // Narrow stall counter instance so saturation is reachable in a few cycles.
  pipeline_hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_re(ex_mem_re), .ex_dest_addr(ex_dest_addr),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .wb_reg_wb(wb_reg_wb), .wb_mem_re(wb_mem_re), .wb_dest_addr(wb_dest_addr),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .exwb_en(s_exwb_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [2:0] id_rs, id_rt;
    logic       uses_rs, uses_rt, ex_mem_re;
    logic [2:0] ex_dest, ex_rs, ex_rt;
    logic       wb_reg_wb, wb_mem_re;
    logic [2:0] wb_dest;
    logic       branch, req, ack;
    logic [5:0] exp_ctrl;
    logic [1:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [5:0] ctrl_bits();
    return {pc_en, if_id_en, id_ex_en, exwb_en, if_id_flush, id_ex_flush};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else n_passed++;
  endtask

  task automatic idle_inputs();
    id_rs_addr = 3'd0; id_rt_addr = 3'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_re = 1'b0; ex_dest_addr = 3'd0; ex_rs_addr = 3'd0; ex_rt_addr = 3'd0;
    wb_reg_wb = 1'b0; wb_mem_re = 1'b0; wb_dest_addr = 3'd0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs_addr = v.id_rs; id_rt_addr = v.id_rt; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    ex_mem_re = v.ex_mem_re; ex_dest_addr = v.ex_dest; ex_rs_addr = v.ex_rs; ex_rt_addr = v.ex_rt;
    wb_reg_wb = v.wb_reg_wb; wb_mem_re = v.wb_mem_re; wb_dest_addr = v.wb_dest;
    branch_taken = v.branch; mem_req = v.req; mem_ack = v.ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    //           name           rs  rt  urs urt lre dst ers ert wbw wbr wbd br  req ack  ctrl   a      b
    vecs[0]  = '{"idle",        0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  C_RUN, 2'b00, 2'b00};
    vecs[1]  = '{"lu_rs",       3,  1,  1,  0,  1,  3,  0,  0,  0,  0,  0,  0,  0,  0,  C_LU,  2'b00, 2'b00};
    vecs[2]  = '{"lu_rt",       2,  6,  1,  1,  1,  6,  0,  0,  0,  0,  0,  0,  0,  0,  C_LU,  2'b00, 2'b00};
    vecs[3]  = '{"no_use",      3,  3,  0,  0,  1,  3,  0,  0,  0,  0,  0,  0,  0,  0,  C_RUN, 2'b00, 2'b00};
    vecs[4]  = '{"not_load",    3,  3,  1,  1,  0,  3,  0,  0,  0,  0,  0,  0,  0,  0,  C_RUN, 2'b00, 2'b00};
    vecs[5]  = '{"lu_r0",       0,  4,  1,  0,  1,  0,  1,  1,  0,  0,  0,  0,  0,  0,  C_LU,  2'b00, 2'b00};
    vecs[6]  = '{"br_and_lu",   3,  0,  1,  0,  1,  3,  0,  0,  0,  0,  0,  1,  0,  0,  C_BR,  2'b00, 2'b00};
    vecs[7]  = '{"br_only",     0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  C_BR,  2'b00, 2'b00};
    vecs[8]  = '{"fwd_alu",     0,  0,  0,  0,  0,  0,  5,  5,  1,  0,  5,  0,  0,  0,  C_RUN, 2'b01, 2'b01};
    vecs[9]  = '{"fwd_ram",     0,  0,  0,  0,  0,  0,  5,  5,  1,  1,  5,  0,  0,  0,  C_RUN, 2'b10, 2'b10};
    vecs[10] = '{"fwd_a_only",  0,  0,  0,  0,  0,  0,  5,  4,  1,  0,  5,  0,  0,  0,  C_RUN, 2'b01, 2'b00};
    vecs[11] = '{"fwd_no_wb",   0,  0,  0,  0,  0,  0,  5,  5,  0,  1,  5,  0,  0,  0,  C_RUN, 2'b00, 2'b00};
    vecs[12] = '{"fwd_in_lu",   2,  0,  1,  0,  1,  2,  1,  7,  1,  1,  7,  0,  0,  0,  C_LU,  2'b00, 2'b10};
    vecs[13] = '{"req_acked",   0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  C_RUN, 2'b00, 2'b00};

    reset = 1'b0;
    idle_inputs();
    tick();

    // Reset forces every control output low even with hazards and forwarding present.
    apply(vecs[9]);
    branch_taken = 1'b1;
    @(negedge clk);
    check("reset_ctrl", ctrl_bits(), C_FRZ);
    check("reset_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    tick();
    @(negedge clk);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_timeout", mem_timeout, 0);
    reset = 1'b1;
    idle_inputs();
    tick();

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check({vecs[i].name, "_ctrl"}, ctrl_bits(), vecs[i].exp_ctrl);
      check({vecs[i].name, "_fwd_a"}, fwd_a_sel, vecs[i].exp_a);
      check({vecs[i].name, "_fwd_b"}, fwd_b_sel, vecs[i].exp_b);
      tick();
    end
    idle_inputs();

    // Load-use stall lasts one cycle once the load leaves EX.
    do_reset();
    ex_mem_re = 1'b1; ex_dest_addr = 3'd3; id_rs_addr = 3'd3; id_uses_rs = 1'b1;
    @(negedge clk);
    check("seq_lu_stall", ctrl_bits(), C_LU);
    tick();
    idle_inputs();
    @(negedge clk);
    check("seq_lu_release", ctrl_bits(), C_RUN);
    check("seq_lu_stall_cnt", stall_cnt, 1);
    tick();

    // RAM access acked on the 5th cycle; a branch raised during the wait is honoured at release.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= 1) branch_taken = 1'b1;
      @(negedge clk);
      check($sformatf("seq_mem_wait%0d", i), ctrl_bits(), C_FRZ);
      tick();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    check("seq_mem_ack_cycle", ctrl_bits(), C_BR);
    tick();
    idle_inputs();
    @(negedge clk);
    check("seq_mem_stall_cnt", stall_cnt, 4);
    check("seq_mem_after", ctrl_bits(), C_RUN);
    tick();

    // Never-acked access: one RUN cycle plus 15 wait cycles, then forced release.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0 || i >= 14) begin
        check($sformatf("seq_tmo_frozen%0d", i), ctrl_bits(), C_FRZ);
        check($sformatf("seq_tmo_flag_low%0d", i), mem_timeout, 0);
      end
      tick();
    end
    mem_req = 1'b0;
    @(negedge clk);
    check("seq_tmo_flag_set", mem_timeout, 1);
    check("seq_tmo_released", ctrl_bits(), C_RUN);
    check("seq_tmo_stall_cnt", stall_cnt, 16);
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    check("seq_tmo_sticky", mem_timeout, 1);
    do_reset();
    @(negedge clk);
    check("seq_tmo_cleared", mem_timeout, 0);
    tick();

    // Branch and load-use together: flush only, never a stall.
    do_reset();
    apply(vecs[6]);
    @(negedge clk);
    check("seq_br_lu_ctrl", ctrl_bits(), C_BR);
    tick();
    idle_inputs();
    @(negedge clk);
    check("seq_br_lu_no_stall", stall_cnt, 0);
    check("seq_br_lu_next", ctrl_bits(), C_RUN);
    tick();

    // Reset during a RAM wait abandons it.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    wb_reg_wb = 1'b1; wb_dest_addr = 3'd2; ex_rs_addr = 3'd2;
    @(negedge clk);
    check("seq_rst_wait_ctrl", ctrl_bits(), C_FRZ);
    check("seq_rst_wait_fwd", fwd_a_sel, 2'b00);
    tick();
    @(negedge clk);
    check("seq_rst_wait_cnt", stall_cnt, 0);
    tick();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("seq_rst_wait_run", ctrl_bits(), C_RUN);
    tick();

    // Continuous load-use: wide counter counts, narrow counter saturates.
    do_reset();
    ex_mem_re = 1'b1; ex_dest_addr = 3'd4; id_rt_addr = 3'd4; id_uses_rt = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    idle_inputs();
    @(negedge clk);
    check("seq_sat_wide", stall_cnt, 20);
    check("seq_sat_narrow", s_stall_cnt, 15);
    tick();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
